cl_conveyer_prio_n: RTL and testbench

//  N-input priority conveyer stage: merges N_IN AXI-Stream-style input channels onto one conveyer lane.

---
 rtl/cl_conveyer_pkg.sv | 18 +
 rtl/cl_conveyer_skid_buf.sv | 84 ++++++++
 rtl/cl_conveyer_prio_n.sv | 115 +++++++++++
 tb/tb_cl_conveyer_prio_n.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cl_conveyer_pkg.sv
// Shared constants and helpers for the priority conveyer stage.
package cl_conveyer_pkg;

  // Output skid buffer depth and the width of its occupancy count.
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = 2;

  // Ceiling log2 that never returns less than 1, so tags stay legal for N_IN==1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = 32'(i) + 32'd1;
    end
    return (r == 0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/cl_conveyer_skid_buf.sv
// Two-entry output FIFO; the head entry drives the registered output port.
module cl_conveyer_skid_buf
  import cl_conveyer_pkg::*;
#(
  parameter type         T    = logic [7:0],
  parameter int unsigned ID_W = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  i_push,
  input  T                      i_data,
  input  logic [ID_W-1:0]       i_id,
  input  logic                  i_pop_rdy,
  output logic [SKID_CNT_W-1:0] o_count,
  output logic                  o_valid,
  output T                      o_data,
  output logic [ID_W-1:0]       o_id
);

  T                      r_head_data;
  logic [ID_W-1:0]       r_head_id;
  T                      r_tail_data;
  logic [ID_W-1:0]       r_tail_id;
  logic [SKID_CNT_W-1:0] r_count;
  logic                  r_valid;
  logic                  w_pop;

  assign w_pop = r_valid & i_pop_rdy;

  // Push/pop bookkeeping; head always holds the oldest entry.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_head_data <= '0;
      r_head_id   <= '0;
      r_tail_data <= '0;
      r_tail_id   <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
    end else begin
      case (r_count)
        SKID_CNT_W'(0): begin
          if (i_push) begin
            r_head_data <= i_data;
            r_head_id   <= i_id;
            r_count     <= SKID_CNT_W'(1);
            r_valid     <= 1'b1;
          end
        end
        SKID_CNT_W'(1): begin
          if (i_push && w_pop) begin
            r_head_data <= i_data;
            r_head_id   <= i_id;
          end else if (i_push) begin
            r_tail_data <= i_data;
            r_tail_id   <= i_id;
            r_count     <= SKID_CNT_W'(2);
          end else if (w_pop) begin
            r_count <= SKID_CNT_W'(0);
            r_valid <= 1'b0;
          end
        end
        default: begin
          // Full: the caller never pushes without a pop here, but keep it safe.
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_id   <= r_tail_id;
            if (i_push) begin
              r_tail_data <= i_data;
              r_tail_id   <= i_id;
            end else begin
              r_count <= SKID_CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_data  = r_head_data;
  assign o_id    = r_head_id;

endmodule

// File: rtl/cl_conveyer_prio_n.sv
// N-input priority merge onto one conveyer lane with aging and a 2-entry skid output.
module cl_conveyer_prio_n
  import cl_conveyer_pkg::*;
#(
  parameter type         T            = logic [7:0],
  parameter int unsigned N_IN         = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ID_W         = clog2_min1(N_IN)
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  T                in_tdata  [N_IN],
  input  logic [N_IN-1:0] in_tvalid,
  output logic [N_IN-1:0] in_tready,
  output T                out_tdata,
  output logic [ID_W-1:0] out_tid,
  output logic            out_tvalid,
  input  logic            out_tready
);

  localparam int unsigned CNT_W = clog2_min1(STARVE_LIMIT + 1);

  logic [1:0]            r_rst_q;
  logic                  w_rst;
  logic [SKID_CNT_W-1:0] w_count;
  logic                  w_space;
  logic [N_IN-1:0]       w_starving;
  logic                  w_gnt_vld;
  logic [ID_W-1:0]       w_gnt_idx;
  logic                  w_accept;

  // Reset asserts immediately and releases on a clock edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_rst_q <= 2'b11;
    else         r_rst_q <= {r_rst_q[0], 1'b0};
  end

  assign w_rst = r_rst_q[1];

  // Space is taken from the registered count only, so out_tready never reaches in_tready.
  assign w_space  = (w_count < SKID_CNT_W'(SKID_DEPTH)) && !w_rst;
  assign w_accept = w_gnt_vld & w_space;

  // Lowest-index starving channel wins; otherwise lowest-index valid channel.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = int'(N_IN) - 1; i >= 0; i--) begin
      if (in_tvalid[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = ID_W'(i);
      end
    end
    if (|w_starving) begin
      for (int i = int'(N_IN) - 1; i >= 0; i--) begin
        if (w_starving[i]) w_gnt_idx = ID_W'(i);
      end
    end
  end

  // One-hot ready towards the granted channel only.
  always_comb begin
    in_tready = '0;
    if (w_accept) in_tready[w_gnt_idx] = 1'b1;
  end

  generate
    if (STARVE_LIMIT != 0) begin : g_age
      logic [CNT_W-1:0] r_wait_cnt [N_IN];

      // Count foreign grants seen while waiting; clear on own grant or when idle.
      always_ff @(posedge clock_i or posedge w_rst) begin
        if (w_rst) begin
          for (int i = 0; i < int'(N_IN); i++) r_wait_cnt[i] <= '0;
        end else if (w_accept) begin
          for (int i = 0; i < int'(N_IN); i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
              r_wait_cnt[i] <= '0;
            end else if (in_tvalid[i]) begin
              if (r_wait_cnt[i] != CNT_W'(STARVE_LIMIT))
                r_wait_cnt[i] <= r_wait_cnt[i] + CNT_W'(1);
            end else begin
              r_wait_cnt[i] <= '0;
            end
          end
        end
      end

      // A waiting channel that has hit the limit forces its way in.
      always_comb begin
        for (int i = 0; i < int'(N_IN); i++)
          w_starving[i] = in_tvalid[i] && (r_wait_cnt[i] == CNT_W'(STARVE_LIMIT));
      end
    end else begin : g_no_age
      assign w_starving = '0;
    end
  endgenerate

  cl_conveyer_skid_buf #(
    .T    (T),
    .ID_W (ID_W)
  ) u_skid (
    .clock_i   (clock_i),
    .reset_i   (w_rst),
    .i_push    (w_accept),
    .i_data    (in_tdata[w_gnt_idx]),
    .i_id      (w_gnt_idx),
    .i_pop_rdy (out_tready),
    .o_count   (w_count),
    .o_valid   (out_tvalid),
    .o_data    (out_tdata),
    .o_id      (out_tid)
  );

endmodule

// File: tb/tb_cl_conveyer_prio_n.sv
// Directed vector bench for cl_conveyer_prio_n (aging instance plus strict-priority instance).
module tb_cl_conveyer_prio_n;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic [7:0] in_tdata [4];
  logic [3:0] in_tvalid;
  logic       out_tready;

  logic [3:0] a_in_tready, b_in_tready;
  logic [7:0] a_odata, b_odata;
  logic [1:0] a_otid, b_otid;
  logic       a_ov, b_ov;

  always #5 clock_i = ~clock_i;

  cl_conveyer_prio_n #(.T(logic [7:0]), .N_IN(4), .STARVE_LIMIT(3)) u_dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (a_in_tready),
    .out_tdata  (a_odata),
    .out_tid    (a_otid),
    .out_tvalid (a_ov),
    .out_tready (out_tready)
  );

  cl_conveyer_prio_n #(.T(logic [7:0]), .N_IN(4), .STARVE_LIMIT(0)) u_dut_strict (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (b_in_tready),
    .out_tdata  (b_odata),
    .out_tid    (b_otid),
    .out_tvalid (b_ov),
    .out_tready (out_tready)
  );

  typedef struct {
    logic [3:0]  v;
    logic        ordy;
    logic [31:0] din;
    logic [3:0]  er;
    logic        eov;
    logic [1:0]  etid;
    logic [7:0]  ed;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic ordy, input logic [31:0] din,
                     input logic [3:0] er, input logic eov, input logic [1:0] etid, input logic [7:0] ed);
    vec_t t;
    t.v = v; t.ordy = ordy; t.din = din; t.er = er; t.eov = eov; t.etid = etid; t.ed = ed;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic [3:0] v, input logic ordy, input logic [31:0] din);
    in_tvalid  = v;
    out_tready = ordy;
    for (int i = 0; i < 4; i++) in_tdata[i] = din[8*i +: 8];
  endtask

  // Channel i carries {i, k} in vector k.
  function automatic logic [31:0] mk(input int k);
    logic [3:0] n;
    n = 4'(k);
    return {4'h3, n, 4'h2, n, 4'h1, n, 4'h0, n};
  endfunction

  // Apply vectors [lo,hi): drive after posedge, check at negedge.
  task automatic run_range(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      drive(vecs[k].v, vecs[k].ordy, vecs[k].din);
      @(negedge clock_i);
      check("in_tready", k, 32'(a_in_tready), 32'(vecs[k].er));
      check("out_tvalid", k, 32'(a_ov), 32'(vecs[k].eov));
      if (vecs[k].eov) begin
        check("out_tid", k, 32'(a_otid), 32'(vecs[k].etid));
        check("out_tdata", k, 32'(a_odata), 32'(vecs[k].ed));
      end
      @(posedge clock_i);
      #1;
    end
  endtask

  initial begin
    int lo;
    reset_i = 1'b1;
    drive(4'b0000, 1'b0, 32'h0);
    repeat (3) @(posedge clock_i);
    #1 reset_i = 1'b0;
    repeat (3) @(posedge clock_i);
    #1;

    // Reset state
    @(negedge clock_i);
    check("rst_out_tvalid", 0, 32'(a_ov), 32'h0);
    check("rst_out_tid", 0, 32'(a_otid), 32'h0);
    check("rst_out_tdata", 0, 32'(a_odata), 32'h0);
    check("rst_in_tready", 0, 32'(a_in_tready), 32'h0);
    @(posedge clock_i);
    #1;

    // Aging (ch0+ch2), mixed sets, full+pop, all-valid rotation
    add(4'b0000, 1, mk(0),  4'b0000, 0, 0, 8'h00);
    add(4'b0101, 1, mk(1),  4'b0001, 0, 0, 8'h00);
    add(4'b0101, 1, mk(2),  4'b0001, 1, 0, 8'h01);
    add(4'b0101, 1, mk(3),  4'b0001, 1, 0, 8'h02);
    add(4'b0101, 1, mk(4),  4'b0100, 1, 0, 8'h03);
    add(4'b0101, 1, mk(5),  4'b0001, 1, 2, 8'h24);
    add(4'b0101, 1, mk(6),  4'b0001, 1, 0, 8'h05);
    add(4'b0101, 1, mk(7),  4'b0001, 1, 0, 8'h06);
    add(4'b0101, 1, mk(8),  4'b0100, 1, 0, 8'h07);
    add(4'b1110, 1, mk(9),  4'b0010, 1, 2, 8'h28);
    add(4'b1100, 1, mk(10), 4'b0100, 1, 1, 8'h19);
    add(4'b1000, 1, mk(11), 4'b1000, 1, 2, 8'h2A);
    add(4'b1111, 0, mk(12), 4'b0001, 1, 3, 8'h3B);
    add(4'b1111, 0, mk(13), 4'b0000, 1, 3, 8'h3B);
    add(4'b1111, 1, mk(14), 4'b0000, 1, 3, 8'h3B);
    add(4'b1111, 1, mk(15), 4'b0001, 1, 0, 8'h0C);
    add(4'b1111, 1, mk(16), 4'b0001, 1, 0, 8'h0F);
    add(4'b1111, 1, mk(17), 4'b0010, 1, 0, 8'h00);
    add(4'b1111, 1, mk(18), 4'b0100, 1, 1, 8'h11);
    add(4'b1111, 1, mk(19), 4'b1000, 1, 2, 8'h22);
    add(4'b1111, 1, mk(20), 4'b0001, 1, 3, 8'h33);
    add(4'b0000, 1, mk(21), 4'b0000, 1, 0, 8'h04);
    add(4'b0000, 1, mk(22), 4'b0000, 0, 0, 8'h00);

    // Single channel ch1 stream 0x10..0x1F
    for (int j = 0; j < 16; j++)
      add(4'b0010, 1, 32'(8'h10 + j) << 8, 4'b0010, (j > 0), 2'd1, 8'(8'h0F + j));
    add(4'b0000, 1, 32'h0, 4'b0000, 1, 1, 8'h1F);
    add(4'b0000, 1, 32'h0, 4'b0000, 0, 0, 8'h00);

    // Backpressure on ch0 for 5 cycles, then release
    add(4'b0001, 0, 32'hA0, 4'b0001, 0, 0, 8'h00);
    add(4'b0001, 0, 32'hA1, 4'b0001, 1, 0, 8'hA0);
    add(4'b0001, 0, 32'hA2, 4'b0000, 1, 0, 8'hA0);
    add(4'b0001, 0, 32'hA2, 4'b0000, 1, 0, 8'hA0);
    add(4'b0001, 0, 32'hA2, 4'b0000, 1, 0, 8'hA0);
    add(4'b0001, 1, 32'hA2, 4'b0000, 1, 0, 8'hA0);
    add(4'b0001, 1, 32'hA2, 4'b0001, 1, 0, 8'hA1);
    add(4'b0001, 1, 32'hA3, 4'b0001, 1, 0, 8'hA2);
    add(4'b0000, 1, 32'h0,  4'b0000, 1, 0, 8'hA3);
    add(4'b0000, 1, 32'h0,  4'b0000, 0, 0, 8'h00);

    // Fill with ch2 while ch3 waits (ch3 counter reaches 2)
    add(4'b1100, 0, 32'h6655_0000, 4'b0100, 0, 0, 8'h00);
    add(4'b1100, 0, 32'h6656_0000, 4'b0100, 1, 2, 8'h55);
    add(4'b1100, 0, 32'h6656_0000, 4'b0000, 1, 2, 8'h55);

    run_range(0, vecs.size());

    // Reset mid-stream with two items buffered and ch2 valid
    #2 reset_i = 1'b1;
    #1;
    check("midrst_out_tvalid", 0, 32'(a_ov), 32'h0);
    check("midrst_in_tready", 0, 32'(a_in_tready), 32'h0);
    drive(4'b0000, 1'b1, 32'h0);
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b0;
    repeat (3) @(posedge clock_i);
    #1;

    // Counters restart at 0: ch3 needs three ch2 grants before it is forced in
    lo = vecs.size();
    add(4'b1100, 1, 32'h6670_0000, 4'b0100, 0, 0, 8'h00);
    add(4'b1100, 1, 32'h6671_0000, 4'b0100, 1, 2, 8'h70);
    add(4'b1100, 1, 32'h6672_0000, 4'b0100, 1, 2, 8'h71);
    add(4'b1100, 1, 32'h6673_0000, 4'b1000, 1, 2, 8'h72);
    add(4'b0000, 1, 32'h0,         4'b0000, 1, 3, 8'h66);
    add(4'b0000, 1, 32'h0,         4'b0000, 0, 0, 8'h00);
    run_range(lo, vecs.size());

    // Strict priority instance: ch3 never gets ready while ch0 is valid
    for (int j = 0; j < 8; j++) begin
      drive(4'b1001, 1'b1, mk(j));
      @(negedge clock_i);
      check("strict_in_tready", j, 32'(b_in_tready), 32'h1);
      if (j > 0) begin
        check("strict_out_tvalid", j, 32'(b_ov), 32'h1);
        check("strict_out_tid", j, 32'(b_otid), 32'h0);
      end
      @(posedge clock_i);
      #1;
    end
    drive(4'b0000, 1'b1, 32'h0);
    repeat (2) @(posedge clock_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
